// File: rtl/mnist_pixel_streamer_if.sv
// Bus bundle for mnist_pixel_streamer: row-write port, start request and
// the serial pixel stream with its frame/position qualifiers.
`timescale 1ns/1ps
interface mnist_pixel_streamer_if;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [27:0] wr_data;
  logic        start;
  logic        busy;
  logic        load;
  logic        pixel;
  logic        pixel_valid;
  logic [4:0]  H_count;
  logic [4:0]  V_count;
  logic        done;

  modport master (
    output wr_en, wr_row, wr_data, start,
    input  busy, load, pixel, pixel_valid, H_count, V_count, done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, start,
    output busy, load, pixel, pixel_valid, H_count, V_count, done
  );
endinterface

// File: rtl/mnist_pixel_streamer.sv
// mnist_pixel_streamer: holds a 28x28 binary image written one row at a time
// and streams it out as a raster-ordered serial pixel stream.
// Optional build macro STREAM_ROW_GAP_EN inserts one idle (GAP) cycle after
// every row except the last.
//
// state  | meaning
// IDLE   | waiting for start; row writes accepted
// STREAM | a valid pixel is on the outputs
// GAP    | one-cycle pause between rows (macro build only)
// DONE   | one-cycle done pulse after the last pixel
`timescale 1ns/1ps
module mnist_pixel_streamer (
  input logic clk,
  input logic reset,
  mnist_pixel_streamer_if.slave bus
);

`ifdef STREAM_ROW_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

  state_t      state_q, state_d;
  logic [27:0] img_q [28];
  logic        busy_q, busy_d;
  logic        load_q, load_d;
  logic        pixel_q, pixel_d;
  logic        pv_q, pv_d;
  logic        done_q, done_d;
  logic [4:0]  h_q, h_d;
  logic [4:0]  v_q, v_d;

  logic        wr_ok;
  logic [27:0] row0_fwd;
  logic [4:0]  nh, nv, nv_idx;
  logic [27:0] nrow;

  // Writes only land while idle and only for real rows.
  assign wr_ok = bus.wr_en && (bus.wr_row <= 5'd27) && (state_q == IDLE);

  // A row-0 write in the start cycle must show up in the very first pixel.
  assign row0_fwd = (wr_ok && (bus.wr_row == 5'd0)) ? bus.wr_data : img_q[0];

  // Raster successor of the current position; also valid when leaving GAP,
  // because H holds 27 there.
  assign nh     = (h_q == 5'd27) ? 5'd0 : h_q + 5'd1;
  assign nv     = (h_q == 5'd27) ? v_q + 5'd1 : v_q;
  assign nv_idx = (nv > 5'd27) ? 5'd0 : nv;
  assign nrow   = img_q[nv_idx];

  // Image store: cleared by reset, overwritten a row at a time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 28; i++) img_q[i] <= '0;
    end else if (wr_ok) begin
      img_q[bus.wr_row] <= bus.wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      pixel_q <= 1'b0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      h_q     <= 5'd0;
      v_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      pixel_q <= pixel_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    load_d  = 1'b0;
    pixel_d = 1'b0;
    pv_d    = 1'b0;
    done_d  = 1'b0;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          h_d     = 5'd0;
          v_d     = 5'd0;
          busy_d  = 1'b1;
          load_d  = 1'b1;
          pv_d    = 1'b1;
          pixel_d = row0_fwd[27];
        end
      end
      STREAM: begin
        if (h_q == 5'd27 && v_q == 5'd27) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (h_q == 5'd27 && GapEn) begin
          state_d = GAP;
          busy_d  = 1'b1;
        end else begin
          h_d     = nh;
          v_d     = nv;
          busy_d  = 1'b1;
          pv_d    = 1'b1;
          pixel_d = nrow[5'd27 - nh];
        end
      end
      GAP: begin
        state_d = STREAM;
        h_d     = nh;
        v_d     = nv;
        busy_d  = 1'b1;
        pv_d    = 1'b1;
        pixel_d = nrow[5'd27 - nh];
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.load        = load_q;
  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pv_q;
  assign bus.done        = done_q;
  assign bus.H_count     = h_q;
  assign bus.V_count     = v_q;

endmodule

// File: tb/tb_mnist_pixel_streamer.sv
// Testbench for mnist_pixel_streamer: directed sequence with random image
// contents, checked against an array model of the image and raster order.
`timescale 1ns/1ps
module tb_mnist_pixel_streamer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mnist_pixel_streamer_if bus();

  mnist_pixel_streamer dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

`ifdef STREAM_ROW_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [27:0] img [28];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] row, input logic [27:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_row  = row;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    if (row <= 5'd27) img[row] = data;
  endtask

  task automatic chk_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pv"}, 32'(bus.pixel_valid), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_pix"}, 32'(bus.pixel), 32'd0);
      tick();
    end
  endtask

  // Starts a frame and checks every cycle of it. disturb injects start pulses
  // and a row-3 write mid-frame, which must have no effect.
  task automatic stream_frame(input bit disturb, input bit wr_same, input logic [4:0] wrow,
                              input logic [27:0] wdata);
    int          cyc;
    int          pv_cnt;
    logic [27:0] r;
    bus.start = 1'b1;
    if (wr_same) begin
      bus.wr_en   = 1'b1;
      bus.wr_row  = wrow;
      bus.wr_data = wdata;
      if (wrow <= 5'd27) img[wrow] = wdata;
    end
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    cyc    = 1;
    pv_cnt = 0;
    for (int v = 0; v < 28; v++) begin
      for (int h = 0; h < 28; h++) begin
        r = img[v];
        chk("pv", 32'(bus.pixel_valid), 32'd1);
        chk("pixel", 32'(bus.pixel), 32'(r[27 - h]));
        chk("H", 32'(bus.H_count), 32'(h));
        chk("V", 32'(bus.V_count), 32'(v));
        chk("load", 32'(bus.load), (v == 0 && h == 0) ? 32'd1 : 32'd0);
        chk("busy", 32'(bus.busy), 32'd1);
        chk("done_early", 32'(bus.done), 32'd0);
        if (bus.pixel_valid === 1'b1) pv_cnt++;
        bus.start   = disturb && (cyc == 9 || cyc == 299);
        bus.wr_en   = disturb && (cyc == 99);
        bus.wr_row  = 5'd3;
        bus.wr_data = 28'h0;
        tick();
        cyc++;
        if (GapEn && h == 27 && v < 27) begin
          chk("gap_pv", 32'(bus.pixel_valid), 32'd0);
          chk("gap_busy", 32'(bus.busy), 32'd1);
          chk("gap_pix", 32'(bus.pixel), 32'd0);
          chk("gap_load", 32'(bus.load), 32'd0);
          chk("gap_H", 32'(bus.H_count), 32'd27);
          bus.start   = disturb && (cyc == 9 || cyc == 299);
          bus.wr_en   = disturb && (cyc == 99);
          tick();
          cyc++;
        end
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    chk("done", 32'(bus.done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_pv", 32'(bus.pixel_valid), 32'd0);
    chk("done_H", 32'(bus.H_count), 32'd27);
    chk("done_V", 32'(bus.V_count), 32'd27);
    chk("pv_count", 32'(pv_cnt), 32'd784);
    tick();
    chk("done_pulse_end", 32'(bus.done), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_pv", 32'(bus.pixel_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rr;
    logic [27:0] rd;
    bus.wr_en   = 1'b0;
    bus.wr_row  = 5'd0;
    bus.wr_data = 28'h0;
    bus.start   = 1'b0;
    for (int i = 0; i < 28; i++) img[i] = 28'h0;

    // Reset state.
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_H", 32'(bus.H_count), 32'd0);
    chk("rst_V", 32'(bus.V_count), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_load", 32'(bus.load), 32'd0);
    reset = 1'b1;
    tick();
    chk_quiet(5, "idle_after_rst");
    chk("idle_H", 32'(bus.H_count), 32'd0);

    // Row 0 corner pixels set.
    do_write(5'd0, 28'h8000001);
    stream_frame(1'b0, 1'b0, 5'd0, 28'h0);

    // All ones.
    for (int i = 0; i < 28; i++) do_write(5'(i), 28'hFFFFFFF);
    stream_frame(1'b0, 1'b0, 5'd0, 28'h0);

    // Random image, random stray writes, mid-frame disturbances.
    for (int i = 0; i < 28; i++) do_write(5'(i), 28'($urandom));
    for (int i = 0; i < 6; i++) do_write(5'($urandom_range(31, 0)), 28'($urandom));
    do_write(5'd3, 28'($urandom) | 28'h1);
    stream_frame(1'b1, 1'b0, 5'd0, 28'h0);
    chk_quiet(20, "no_second_frame");

    // Write in the same cycle as start.
    stream_frame(1'b0, 1'b1, 5'd0, 28'($urandom));
    rr = 5'($urandom_range(27, 1));
    rd = 28'($urandom);
    stream_frame(1'b0, 1'b1, rr, rd);

    // Reset in the middle of a frame.
    for (int i = 0; i < 28; i++) do_write(5'(i), 28'hFFFFFFF);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 400; i++) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_pv", 32'(bus.pixel_valid), 32'd0);
    chk("mid_rst_pix", 32'(bus.pixel), 32'd0);
    chk("mid_rst_load", 32'(bus.load), 32'd0);
    chk("mid_rst_H", 32'(bus.H_count), 32'd0);
    chk("mid_rst_V", 32'(bus.V_count), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 28; i++) img[i] = 28'h0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_quiet(10, "quiet_after_mid_rst");

    // Out-of-range row write is dropped.
    do_write(5'd30, 28'hFFFFFFF);
    stream_frame(1'b0, 1'b0, 5'd0, 28'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mnist_pixel_streamer.md
MNIST_PIXEL_STREAMER -- requirements
Module: mnist_pixel_streamer

Interface
REQ-001 clk  input  1  rising-edge system clock; sole clock.
REQ-002 reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
REQ-003 wr_en  input  1  row-write strobe into internal 28x28 image store.
REQ-004 wr_row  input  5  row index 0..27 for the write.
REQ-005 wr_data  input  28  row bits; column c = wr_data[27-c] (MSB first).
REQ-006 start  input  1  single-cycle request to stream the stored image.
REQ-007 busy  output  1  high while streaming.
REQ-008 load  output  1  frame-start strobe; high with the first pixel only.
REQ-009 pixel  output  1  serial binary pixel, registered.
REQ-010 pixel_valid  output  1  pixel carries image data this cycle.
REQ-011 H_count  output  5  column (0..27) of the current pixel.
REQ-012 V_count  output  5  row (0..27) of the current pixel.
REQ-013 done  output  1  one-cycle pulse after the last pixel.

Function
REQ-014 Image store SHALL be 28 registers of 28 bits; wr_en with wr_row<=27 in IDLE SHALL overwrite that row at the clock edge.
REQ-015 Writes with wr_row>=28, or any write while busy=1, SHALL be dropped with no effect.
REQ-016 FSM states SHALL be IDLE, STREAM, GAP, DONE.
REQ-017 IDLE: start=1 -> STREAM next cycle; start SHALL be ignored in all other states.
REQ-018 First STREAM cycle SHALL present row 0 col 0 with load=1, pixel_valid=1, busy=1; latency start to first pixel = 1 cycle.
REQ-019 Order SHALL be raster: H_count increments each valid cycle, wraps 27->0 with V_count incrementing.
REQ-020 A write and start in the same IDLE cycle SHALL both take effect; the streamed frame SHALL contain the written row.
REQ-021 After row 27 col 27, FSM SHALL enter DONE: done=1, busy=0, pixel_valid=0 for exactly one cycle, then IDLE.
REQ-022 In IDLE, DONE and GAP: pixel=0, pixel_valid=0, load=0; H_count/V_count hold the last values (0 after reset).
REQ-023 Frame length SHALL be exactly 784 valid pixels; counters SHALL never exceed 27.

Reset
REQ-024 reset=0 SHALL force IDLE, busy=0, load=0, pixel=0, pixel_valid=0, done=0, H_count=0, V_count=0 asynchronously, including mid-frame.
REQ-025 Image store SHALL be cleared to all zeros by reset.
REQ-026 After reset release, no pixels SHALL be emitted until a new start.

Configuration
REQ-027 Macro STREAM_ROW_GAP_EN defined: after each row's col 27 (rows 0..26) FSM SHALL spend one cycle in GAP (pixel_valid=0) before the next row; frame = 811 cycles start-to-done-minus-one.
REQ-028 Macro STREAM_ROW_GAP_EN undefined: GAP state SHALL be unreachable; rows stream back-to-back, 784 consecutive valid cycles.

Verification
REQ-029 Reset, write row 0 = 28'h8000001, start -> cycle 1: load=1, pixel=1, H=0,V=0; col 27 pixel=1; cols 1..26 pixel=0.
REQ-030 Write all rows 28'hFFFFFFF, start -> exactly 784 pixel_valid cycles all pixel=1 (no macro), done pulse at cycle 785, busy low same cycle.
REQ-031 With STREAM_ROW_GAP_EN: same stimulus -> 27 single-cycle pixel_valid=0 gaps at H wrap, done at cycle 812.
REQ-032 Start pulses at cycles 10 and 300 mid-frame, wr_en row 3 = 28'h0 at cycle 100 -> single frame, row 3 data unchanged from pre-start value.
REQ-033 reset=0 at pixel 400 -> all outputs 0 within same cycle, store zeroed; start after release -> 784 pixels all 0.
REQ-034 wr_row=30 wr_data=28'hFFFFFFF, then start -> all pixels 0.
